kbd_rx_fifo: RTL and testbench

- Parametrised successor to our PS/2 keyboard receiver.
- The whole block runs in the system clock domain. kbdclk and kbddata are treated as asynchronous inputs and are synchronised and glitch-filtered.
- Receives full PS/2 device-to-host frames (start, DATA_W data bits LSB first, parity, stop) and checks parity, stop bit and a watchdog timeout.
- Good words go into a FIFO with a valid/ready handshake toward the host logic; errors are reported as one-cycle pulses.

---
 rtl/kbd_rx_fifo.sv | 166 ++++++++++++++++
 tb/tb_kbd_rx_fifo.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_rx_fifo.sv
// kbd_rx_fifo: PS/2 device-to-host receiver with input glitch filter, frame
// checks, inter-edge watchdog and a small word FIFO toward the host.
module kbd_rx_fifo #(
   parameter int DATA_W      = 8,
   parameter int FILT_LEN    = 4,
   parameter int TIMEOUT_CYC = 50000,
   parameter int FIFO_DEPTH  = 4,
   parameter int PARITY_ODD  = 1
) (
   input  logic                          sysclk,
   input  logic                          rstn,
   input  logic                          kbdclk,
   input  logic                          kbddata,
   output logic [DATA_W-1:0]             word,
   output logic                          valid,
   input  logic                          ready,
   output logic [1:0]                    s,
   output logic [$clog2(FIFO_DEPTH):0]   fill,
   output logic                          err_parity,
   output logic                          err_frame,
   output logic                          err_timeout,
   output logic                          err_overflow
);
   localparam int FW = $clog2(FILT_LEN);
   localparam int BW = $clog2(DATA_W);
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

   state_t                           state_q, state_d;
   logic [1:0]                       s1_q, s1_d, s2_q, s2_d, filt_q, filt_d, diff, hit;
   logic [1:0][FW-1:0]               fcnt_q, fcnt_d;
   logic                             kc_prev_q, kc_prev_d, fall, kd;
   logic [BW-1:0]                    bitcnt_q, bitcnt_d;
   logic [DATA_W-1:0]                data_q, data_d;
   logic                             par_q, par_d;
   logic [TW-1:0]                    tcnt_q, tcnt_d;
   logic                             ep_q, ep_d, ef_q, ef_d, et_q, et_d, eo_q, eo_d;
   logic                             push_req, push_ok, pop;
   logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
   logic [AW-1:0]                    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]                    fill_q, fill_d;

   // bit 0 carries kbdclk, bit 1 kbddata; counter tracks consecutive disagreeing samples
   always_comb begin
      s1_d      = {kbddata, kbdclk};
      s2_d      = s1_q;
      kc_prev_d = filt_q[0];
      for (int i = 0; i < 2; i++) begin
         diff[i]   = s2_q[i] != filt_q[i];
         hit[i]    = diff[i] && fcnt_q[i] == FW'(FILT_LEN - 1);
         fcnt_d[i] = (diff[i] && !hit[i]) ? fcnt_q[i] + 1'b1 : '0;
         filt_d[i] = hit[i] ? s2_q[i] : filt_q[i];
      end
   end

   assign fall = kc_prev_q & ~filt_q[0];
   assign kd   = filt_q[1];

   always_ff @(posedge sysclk or negedge rstn)
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      data_d   = data_q;
      par_d    = par_q;
      tcnt_d   = (state_q == IDLE || fall) ? '0 : tcnt_q + 1'b1;
      push_req = 1'b0;
      ep_d     = 1'b0;
      ef_d     = 1'b0;
      et_d     = 1'b0;
      if (fall) begin
         case (state_q)
            IDLE: begin
               state_d  = kd ? IDLE : DATA;
               bitcnt_d = '0;
            end
            DATA: begin
               data_d[bitcnt_q] = kd;
               state_d  = (bitcnt_q == BW'(DATA_W - 1)) ? PARITY : DATA;
               bitcnt_d = bitcnt_q + 1'b1;
            end
            PARITY: begin
               par_d   = kd;
               state_d = STOP;
            end
            STOP: begin
               state_d  = IDLE;
               ef_d     = ~kd;
               ep_d     = kd && ((^{data_q, par_q}) != (PARITY_ODD != 0));
               push_req = kd && !ep_d;
            end
         endcase
      end else if (state_q != IDLE && tcnt_d == TW'(TIMEOUT_CYC - 1)) begin
         state_d = IDLE;
         et_d    = 1'b1;
      end
   end

   always_comb begin
      s            = state_q;
      word         = mem_q[rd_q];
      valid        = fill_q != '0;
      fill         = fill_q;
      err_parity   = ep_q;
      err_frame    = ef_q;
      err_timeout  = et_q;
      err_overflow = eo_q;
   end

   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   always_comb begin
      pop     = valid & ready;
      push_ok = push_req & ((fill_q != CW'(FIFO_DEPTH)) | pop);
      eo_d    = push_req & ~push_ok;
      mem_d   = mem_q;
      if (push_ok) mem_d[wr_q] = data_q;
      wr_d    = wr_q + AW'(push_ok);
      rd_d    = rd_q + AW'(pop);
      fill_d  = fill_q + CW'(push_ok) - CW'(pop);
   end

   always_ff @(posedge sysclk or negedge rstn) begin
      if (!rstn) begin
         s1_q      <= '1;
         s2_q      <= '1;
         filt_q    <= '1;
         fcnt_q    <= '0;
         kc_prev_q <= 1'b1;
         bitcnt_q  <= '0;
         data_q    <= '0;
         par_q     <= 1'b0;
         tcnt_q    <= '0;
         ep_q      <= 1'b0;
         ef_q      <= 1'b0;
         et_q      <= 1'b0;
         eo_q      <= 1'b0;
         mem_q     <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
         fill_q    <= '0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         filt_q    <= filt_d;
         fcnt_q    <= fcnt_d;
         kc_prev_q <= kc_prev_d;
         bitcnt_q  <= bitcnt_d;
         data_q    <= data_d;
         par_q     <= par_d;
         tcnt_q    <= tcnt_d;
         ep_q      <= ep_d;
         ef_q      <= ef_d;
         et_q      <= et_d;
         eo_q      <= eo_d;
         mem_q     <= mem_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         fill_q    <= fill_d;
      end
   end
endmodule

// File: tb/tb_kbd_rx_fifo.sv
// tb_kbd_rx_fifo: drives PS/2 frames at the raw pins and checks received words,
// FIFO occupancy and error pulses against a frame-level reference model.
module tb_kbd_rx_fifo;
   localparam int DW = 8, FL = 4, TO = 1000, DEPTH = 4, PODD = 1;

   logic          sysclk = 1'b0, rstn = 1'b0, kbdclk = 1'b1, kbddata = 1'b1, ready = 1'b1;
   logic [DW-1:0] word;
   logic          valid;
   logic [1:0]    s;
   logic [2:0]    fill;
   logic          err_parity, err_frame, err_timeout, err_overflow;

   int tests_run = 0, fails = 0, t_fall = 0;
   int cyc = 0, n_par = 0, n_frm = 0, n_to = 0, n_ovf = 0, n_long = 0, n_fill1 = 0, t_to = 0;
   logic [3:0]    prev_err = '0;
   logic [DW-1:0] got_q[$];

   kbd_rx_fifo #(.DATA_W(DW), .FILT_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH), .PARITY_ODD(PODD)) dut (
      .sysclk(sysclk), .rstn(rstn), .kbdclk(kbdclk), .kbddata(kbddata),
      .word(word), .valid(valid), .ready(ready), .s(s), .fill(fill),
      .err_parity(err_parity), .err_frame(err_frame), .err_timeout(err_timeout), .err_overflow(err_overflow)
   );

   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) cyc <= cyc + 1;

   // mid-cycle observer: records consumed words, error pulses and over-long pulses
   always @(negedge sysclk) begin
      if (rstn) begin
         if (valid && ready) got_q.push_back(word);
         if (valid && fill == 3'd1) n_fill1 <= n_fill1 + 1;
         if (err_parity) n_par <= n_par + 1;
         if (err_frame) n_frm <= n_frm + 1;
         if (err_overflow) n_ovf <= n_ovf + 1;
         if (err_timeout) begin
            n_to <= n_to + 1;
            t_to <= cyc;
         end
         if (({err_parity, err_frame, err_timeout, err_overflow} & prev_err) != 4'd0) n_long <= n_long + 1;
         prev_err <= {err_parity, err_frame, err_timeout, err_overflow};
      end else begin
         prev_err <= '0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sysclk);
         #1;
      end
   endtask

   function automatic logic good_par(input logic [DW-1:0] d);
      return (($countones(d) % 2) == 1) ? (PODD == 0) : (PODD != 0);
   endfunction

   // 0 = good, 1 = parity error, 2 = framing error
   function automatic int classify(input logic [DW-1:0] d, input logic par, input logic stp);
      if (!stp) return 2;
      if ((($countones(d) + int'(par)) % 2) != PODD) return 1;
      return 0;
   endfunction

   function automatic logic [DW-1:0] q_at(input int i);
      return (i < got_q.size()) ? got_q[i] : 8'hxx;
   endfunction

   task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stp,
                             input int half, input bit glitch, input bit pop_stop);
      logic [10:0] b;
      b = {stp, par, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         kbddata = b[i];
         if (glitch && half >= 12) begin
            tick(half / 3);
            kbdclk = 1'b0;
            tick(2);
            kbdclk = 1'b1;
            tick(half - half / 3 - 2);
         end else begin
            tick(half);
         end
         kbdclk = 1'b0;
         t_fall = cyc;
         if (pop_stop && i == 10) begin
            tick(6);
            ready = 1'b1;
            tick(1);
            ready = 1'b0;
            tick(half - 7);
         end else begin
            tick(half);
         end
         kbdclk = 1'b1;
      end
      kbddata = 1'b1;
      tick(2 * half);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      tick(3);
      tests_run++; if (s !== 2'd0) begin fails++; $display("FAIL reset_s: got %0d want 0", s); end
      tests_run++; if (fill !== 3'd0) begin fails++; $display("FAIL reset_fill: got %0d want 0", fill); end
      tests_run++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", valid); end
      tests_run++; if (word !== 8'h00) begin fails++; $display("FAIL reset_word: got %0h want 0", word); end
      tests_run++; if ({err_parity, err_frame, err_timeout, err_overflow} !== 4'b0) begin
         fails++; $display("FAIL reset_err: got %b want 0000", {err_parity, err_frame, err_timeout, err_overflow}); end
      rstn = 1'b1;
      tick(10);
      tests_run++; if (s !== 2'd0) begin fails++; $display("FAIL reset_release_s: got %0d want 0", s); end
   endtask

   task automatic test_basic();
      int g0, f0, e0;
      g0 = got_q.size(); f0 = n_fill1; e0 = n_par + n_frm + n_to + n_ovf;
      ready = 1'b1;
      send_frame(8'h1C, 1'b0, 1'b1, 40, 1'b0, 1'b0);
      tests_run++; if (got_q.size() !== g0 + 1) begin fails++; $display("FAIL basic_count: got %0d want %0d", got_q.size() - g0, 1); end
      tests_run++; if (q_at(g0) !== 8'h1C) begin fails++; $display("FAIL basic_word: got %0h want 1c", q_at(g0)); end
      tests_run++; if (n_fill1 - f0 < 1) begin fails++; $display("FAIL basic_fill1: got %0d cycles want >=1", n_fill1 - f0); end
      tests_run++; if (fill !== 3'd0) begin fails++; $display("FAIL basic_fill0: got %0d want 0", fill); end
      tests_run++; if (n_par + n_frm + n_to + n_ovf !== e0) begin
         fails++; $display("FAIL basic_err: got %0d want 0", n_par + n_frm + n_to + n_ovf - e0); end
   endtask

   task automatic test_parity();
      int g0, p0, o0, l0;
      g0 = got_q.size(); p0 = n_par; o0 = n_frm + n_to + n_ovf; l0 = n_long;
      send_frame(8'h1C, 1'b1, 1'b1, 40, 1'b0, 1'b0);
      tests_run++; if (n_par - p0 !== 1) begin fails++; $display("FAIL parity_err: got %0d want 1", n_par - p0); end
      tests_run++; if (got_q.size() !== g0) begin fails++; $display("FAIL parity_nopush: got %0d want 0", got_q.size() - g0); end
      tests_run++; if (s !== 2'd0) begin fails++; $display("FAIL parity_s: got %0d want 0", s); end
      tests_run++; if (n_frm + n_to + n_ovf !== o0) begin fails++; $display("FAIL parity_other: got %0d want 0", n_frm + n_to + n_ovf - o0); end
      tests_run++; if (n_long !== l0) begin fails++; $display("FAIL parity_pulse_len: got %0d want 0", n_long - l0); end
   endtask

   task automatic test_frame();
      int g0, f0, p0;
      g0 = got_q.size(); f0 = n_frm; p0 = n_par;
      send_frame(8'hF0, good_par(8'hF0), 1'b0, 40, 1'b0, 1'b0);
      tests_run++; if (n_frm - f0 !== 1) begin fails++; $display("FAIL frame_err: got %0d want 1", n_frm - f0); end
      tests_run++; if (n_par !== p0) begin fails++; $display("FAIL frame_parity: got %0d want 0", n_par - p0); end
      tests_run++; if (fill !== 3'd0 || got_q.size() !== g0) begin fails++; $display("FAIL frame_empty: got fill %0d want 0", fill); end
      send_frame(8'h1C, good_par(8'h1C), 1'b1, 40, 1'b0, 1'b0);
      tests_run++; if (q_at(g0) !== 8'h1C) begin fails++; $display("FAIL frame_recover: got %0h want 1c", q_at(g0)); end
   endtask

   task automatic test_overflow();
      int g0, o0;
      logic [DW-1:0] exp_w[5];
      exp_w = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
      g0 = got_q.size(); o0 = n_ovf;
      ready = 1'b0;
      for (int k = 1; k <= 5; k++) send_frame(DW'(k), good_par(DW'(k)), 1'b1, 40, 1'b0, 1'b0);
      tests_run++; if (fill !== 3'd4) begin fails++; $display("FAIL ovf_fill: got %0d want 4", fill); end
      tests_run++; if (n_ovf - o0 !== 1) begin fails++; $display("FAIL ovf_err: got %0d want 1", n_ovf - o0); end
      tests_run++; if (valid !== 1'b1 || word !== 8'h01) begin fails++; $display("FAIL ovf_head: got %0h want 01", word); end
      tests_run++; if (got_q.size() !== g0) begin fails++; $display("FAIL ovf_nopop: got %0d want 0", got_q.size() - g0); end
      send_frame(8'h06, good_par(8'h06), 1'b1, 40, 1'b0, 1'b1);
      tests_run++; if (fill !== 3'd4) begin fails++; $display("FAIL ovf_pushpop_fill: got %0d want 4", fill); end
      tests_run++; if (n_ovf - o0 !== 1) begin fails++; $display("FAIL ovf_pushpop_err: got %0d want 1", n_ovf - o0); end
      ready = 1'b1;
      tick(10);
      tests_run++; if (got_q.size() !== g0 + 5) begin fails++; $display("FAIL ovf_drain_count: got %0d want 5", got_q.size() - g0); end
      for (int k = 0; k < 5; k++) begin
         tests_run++; if (q_at(g0 + k) !== exp_w[k]) begin fails++; $display("FAIL ovf_order[%0d]: got %0h want %0h", k, q_at(g0 + k), exp_w[k]); end
      end
      tests_run++; if (fill !== 3'd0) begin fails++; $display("FAIL ovf_drain_fill: got %0d want 0", fill); end
   endtask

   task automatic test_timeout();
      int t0, o0, g0, lat, n;
      logic [4:0] b;
      b = {8'h5A, 1'b0};
      t0 = n_to; o0 = n_par + n_frm + n_ovf;
      ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         kbddata = b[i];
         tick(40);
         kbdclk = 1'b0;
         t_fall = cyc;
         tick(40);
         kbdclk = 1'b1;
      end
      kbddata = 1'b1;
      n = 0;
      while (n_to == t0 && n < 1300) begin
         tick(1);
         n++;
      end
      lat = t_to - t_fall;
      tests_run++; if (n_to - t0 !== 1) begin fails++; $display("FAIL timeout_err: got %0d want 1", n_to - t0); end
      tests_run++; if (lat < TO + FL + 1 || lat > TO + FL + 3) begin
         fails++; $display("FAIL timeout_latency: got %0d want %0d+-1 from raw edge", lat, TO + FL + 2); end
      tests_run++; if (s !== 2'd0) begin fails++; $display("FAIL timeout_s: got %0d want 0", s); end
      tests_run++; if (n_par + n_frm + n_ovf !== o0) begin fails++; $display("FAIL timeout_other: got %0d want 0", n_par + n_frm + n_ovf - o0); end
      g0 = got_q.size();
      send_frame(8'h5A, good_par(8'h5A), 1'b1, 40, 1'b0, 1'b0);
      tests_run++; if (q_at(g0) !== 8'h5A) begin fails++; $display("FAIL timeout_recover: got %0h want 5a", q_at(g0)); end
      for (int i = 0; i < 3; i++) begin
         kbddata = b[i];
         tick(40);
         kbdclk = 1'b0;
         tick(40);
         kbdclk = 1'b1;
      end
      tick(20);
      rstn = 1'b0;
      #1;
      tests_run++; if (s !== 2'd0) begin fails++; $display("FAIL midreset_s: got %0d want 0", s); end
      tests_run++; if ({err_parity, err_frame, err_timeout, err_overflow, valid} !== 5'b0) begin
         fails++; $display("FAIL midreset_out: got %b want 00000", {err_parity, err_frame, err_timeout, err_overflow, valid}); end
      kbddata = 1'b1;
      tick(3);
      rstn = 1'b1;
      o0 = n_par + n_frm + n_to + n_ovf;
      tick(1200);
      tests_run++; if (n_par + n_frm + n_to + n_ovf !== o0 || s !== 2'd0) begin
         fails++; $display("FAIL midreset_quiet: got %0d errors s=%0d want 0 s=0", n_par + n_frm + n_to + n_ovf - o0, s); end
   endtask

   task automatic test_glitch();
      int g0, e0, bad;
      g0 = got_q.size(); e0 = n_par + n_frm + n_to + n_ovf;
      send_frame(8'h33, good_par(8'h33), 1'b1, 40, 1'b1, 1'b0);
      tests_run++; if (got_q.size() !== g0 + 1 || q_at(g0) !== 8'h33) begin
         fails++; $display("FAIL glitch_word: got %0h (n=%0d) want 33", q_at(g0), got_q.size() - g0); end
      tests_run++; if (n_par + n_frm + n_to + n_ovf !== e0) begin fails++; $display("FAIL glitch_err: got %0d want 0", n_par + n_frm + n_to + n_ovf - e0); end
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         kbdclk = 1'b0;
         tick(1);
         kbdclk = 1'b1;
         for (int j = 0; j < 8; j++) begin
            tick(1);
            if (s != 2'd0) bad++;
         end
      end
      tests_run++; if (bad !== 0) begin fails++; $display("FAIL idle_glitch_s: got %0d non-idle cycles want 0", bad); end
   endtask

   task automatic test_random();
      int g0, p0, f0, ne_par, ne_frm, c;
      logic [DW-1:0] exp_q[$];
      logic [DW-1:0] d;
      logic par, stp;
      int r;
      g0 = got_q.size(); p0 = n_par; f0 = n_frm;
      ne_par = 0; ne_frm = 0;
      ready = 1'b1;
      for (int k = 0; k < 24; k++) begin
         d   = DW'($urandom);
         r   = $urandom_range(0, 5);
         par = good_par(d) ^ (r == 0);
         stp = (r != 1);
         send_frame(d, par, stp, $urandom_range(12, 50), 1'($urandom_range(0, 1)), 1'b0);
         c = classify(d, par, stp);
         if (c == 0) exp_q.push_back(d);
         else if (c == 1) ne_par++;
         else ne_frm++;
      end
      tests_run++; if (n_par - p0 !== ne_par) begin fails++; $display("FAIL rand_parity: got %0d want %0d", n_par - p0, ne_par); end
      tests_run++; if (n_frm - f0 !== ne_frm) begin fails++; $display("FAIL rand_frame: got %0d want %0d", n_frm - f0, ne_frm); end
      tests_run++; if (got_q.size() - g0 !== exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d want %0d", got_q.size() - g0, exp_q.size()); end
      for (int k = 0; k < exp_q.size(); k++) begin
         tests_run++; if (q_at(g0 + k) !== exp_q[k]) begin fails++; $display("FAIL rand_word[%0d]: got %0h want %0h", k, q_at(g0 + k), exp_q[k]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_frame();
      test_overflow();
      test_timeout();
      test_glitch();
      test_random();
      tests_run++; if (n_long !== 0) begin fails++; $display("FAIL pulse_width: got %0d multi-cycle pulses want 0", n_long); end
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
